// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader feeding CPU program memory.
// Frame: SYNC_BYTE, LEN_LO, LEN_HI (word count N), then N little-endian words.
// Holds the CPU in reset until the image has been written to program memory.
// Optional checksum byte after the data: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          PMEM_ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       load_req,
  output logic                       pmem_w_en,
  output logic [PMEM_ADDR_WIDTH-1:0] pmem_addr,
  output logic [31:0]                pmem_w_data,
  output logic                       cpu_rst,
  output logic                       load_done,
  output logic                       load_err,
  output logic [PMEM_ADDR_WIDTH-2:0] words_loaded
);

  localparam int          WLW = PMEM_ADDR_WIDTH - 1;
  localparam logic [16:0] CAP = 17'd1 << (PMEM_ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [15:0]          len_q, len_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          word_q, word_d;
  logic                 wen_q, wen_d;
  logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [WLW-1:0]       words_q, words_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic                 accept;
  logic                 frame_end;
  logic [15:0]          len_new;

  // Byte acceptance depends only on the current state.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA: s_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM:                             s_ready = 1'b1;
`endif
      default:                            s_ready = 1'b0;
    endcase
  end

  assign accept  = s_valid && s_ready;
  assign len_new = {s_data, len_lo_q};

  // Next-state and registered-output logic for the frame parser.
  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    words_d   = words_q;
    frame_end = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept && s_data == SYNC_BYTE) begin
          state_d = S_LEN_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = s_data;
          state_d  = S_LEN_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ s_data;
`endif
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d   = len_new;
          words_d = '0;
          idx_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ s_data;
`endif
          if (len_new == 16'd0) begin
            frame_end = 1'b1;
          end else if ({1'b0, len_new} > CAP) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ s_data;
`endif
          // Bytes shift in from the top so the first byte ends up in [7:0].
          if (idx_q == 2'd3) begin
            wen_d   = 1'b1;
            addr_d  = PMEM_ADDR_WIDTH'({words_q, 2'b00});
            wdata_d = {s_data, word_q};
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            word_d  = {s_data, word_q[23:8]};
            idx_d   = idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        words_d = words_q + 1'b1;
        if ((17'(words_q) + 17'd1) == {1'b0, len_q}) begin
          frame_end = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
          end
        end
      end
`endif

      S_DONE: begin
        if (load_req) begin
          state_d   = S_IDLE;
          done_d    = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end

      S_ERROR: begin
        if (load_req) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      state_d   = S_CSUM;
`else
      state_d   = S_DONE;
      done_d    = 1'b1;
      cpu_rst_d = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      words_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      words_q   <= words_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign pmem_w_en    = wen_q;
  assign pmem_addr    = addr_q;
  assign pmem_w_data  = wdata_q;
  assign cpu_rst      = rst | cpu_rst_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frame-level reference model predicts
// memory writes and final status; a negedge monitor checks every write.
module tb_program_loader;

  localparam int AW  = 12;
  localparam int CAP = 1 << (AW - 2);

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          load_req;
  logic          pmem_w_en;
  logic [AW-1:0] pmem_addr;
  logic [31:0]   pmem_w_data;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW-2:0] words_loaded;

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b1;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;

  program_loader #(.PMEM_ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .load_req(load_req), .pmem_w_en(pmem_w_en), .pmem_addr(pmem_addr),
    .pmem_w_data(pmem_w_data), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next predicted (addr, data).
  always @(negedge clk) begin
    if (!rst && pmem_w_en) begin
      check("s_ready_during_write", 32'(s_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", pmem_addr, pmem_w_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(pmem_addr), 32'(mon_e[43:32]));
        check("wr_data", pmem_w_data, mon_e[31:0]);
      end
    end
  end

  function automatic int find_sync(input bq_t f);
    int i = 0;
    while (i < f.size() && f[i] != 8'hA5) i++;
    return i;
  endfunction

  // Appends the checksum byte when that feature is built in.
  function automatic bq_t with_csum(input bq_t f, input bit bad);
    bq_t  r = f;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    int   i = find_sync(f);
    int   n = int'(f[i+1]) | (int'(f[i+2]) << 8);
    logic [7:0] x = 8'h00;
    if (n <= CAP) begin
      for (int k = i + 1; k < f.size(); k++) x = x ^ f[k];
      r.push_back(bad ? (x ^ 8'h01) : x);
    end
`else
    if (bad) r = f;
`endif
    return r;
  endfunction

  // Reference model: parse the frame and predict writes and final status.
  task automatic model(input bq_t f, output bit e_done, output bit e_err, output int e_words);
    int i = find_sync(f);
    int n = int'(f[i+1]) | (int'(f[i+2]) << 8);
    int base = i + 3;
    e_words = 0;
    if (n > CAP) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({12'(w * 4), f[base+4*w+3], f[base+4*w+2], f[base+4*w+1], f[base+4*w]});
    end
    e_words = n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      for (int k = i + 1; k < base + 4 * n; k++) x = x ^ f[k];
      e_done = (f[base+4*n] == x);
      e_err  = !e_done;
    end
`else
    e_done = 1'b1;
    e_err  = 1'b0;
`endif
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted, s_ready %0b", b, s_ready);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input bq_t f);
    bit e_done, e_err;
    int e_words;
    int t = 0;
    model(f, e_done, e_err, e_words);
    foreach (f[k]) send_byte(f[k]);
    s_valid = 1'b0;
    while (!(load_done || load_err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("load_done", 32'(load_done), 32'(e_done));
    check("load_err", 32'(load_err), 32'(e_err));
    check("cpu_rst_end", 32'(cpu_rst), 32'(!e_done));
    check("s_ready_end", 32'(s_ready), 32'd0);
    if (e_done && e_words > 0) check("words_loaded", 32'(words_loaded), 32'(e_words));
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_done", 32'(load_done), 32'd0);
    check("reload_err", 32'(load_err), 32'd0);
    check("reload_ready", 32'(s_ready), 32'd1);
  endtask

  function automatic bq_t rand_frame(input int n, input int garbage);
    bq_t f;
    for (int g = 0; g < garbage; g++) begin
      logic [7:0] b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      f.push_back(b);
    end
    f.push_back(8'hA5);
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    if (n <= CAP)
      for (int k = 0; k < 4 * n; k++) f.push_back(8'($urandom));
    return f;
  endfunction

  initial begin
    bq_t f;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_w_en", 32'(pmem_w_en), 32'd0);
    check("rst_addr", 32'(pmem_addr), 32'd0);
    check("rst_wdata", pmem_w_data, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("post_rst_ready", 32'(s_ready), 32'd1);

    // Nominal two-word load.
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame(with_csum(f, 1'b0));
    // Garbage before sync.
    f = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(with_csum(f, 1'b0));
    // Oversize length.
    f = '{8'hA5, 8'h01, 8'h04};
    run_frame(f);

    // Reset after the second data byte.
    gaps = 1'b0;
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    foreach (f[k]) send_byte(f[k]);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_w_en", 32'(pmem_w_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(s_ready), 32'd1);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_cpu_rst_after", 32'(cpu_rst), 32'd1);

    // Fresh frame with continuous valid (backpressure during WRITE).
    f = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    run_frame(with_csum(f, 1'b0));
    f = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_frame(with_csum(f, 1'b0));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    f = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_frame(f);
    f = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_frame(f);
`endif

    // Capacity boundary: exactly full, then one word too many.
    run_frame(with_csum(rand_frame(CAP, 0), 1'b0));
    run_frame(rand_frame(CAP + 1, 0));

    // Randomized frames.
    for (int r = 0; r < 20; r++) begin
      gaps = 1'($urandom);
      run_frame(with_csum(rand_frame($urandom_range(0, 6), $urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
